enigma_sink: RTL and testbench

Port-C consumer for the Enigma arbitration buffer. It accepts arbitrated beats (payload, 6-bit id, qos) over a valid/ready handshake and tracks in-flight ids in a 64-bit busy map. A beat whose id is already in flight is rejected with a `conflict_c` pulse. Accepted beats are retired in order after a qos-dependent service delay, and each retirement is reported upstream with `release_c`/`releaseid_c`. Benches use it as the downstream end of the buffer.

---
 rtl/enigma_sink.sv | 180 ++++++++++++++++++
 tb/tb_enigma_sink.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_sink.sv
// ============================================================================
// enigma_sink
//
// Port-C consumer for the Enigma arbitration buffer. Accepts arbitrated beats
// (payload, 6-bit id, qos), tracks in-flight ids in a 64-bit busy map, rejects
// beats whose id is already in flight, and retires accepted beats strictly in
// order after a qos-dependent service delay.
//
// Handshake: a beat transfers on any rising edge where valid_c && ready_c.
// A transferred beat is either enqueued (id was free) or rejected (id was busy,
// conflict_c pulses in the next cycle); it is never stalled. ready_c is
// registered, so upstream sees it one cycle ahead of the edge it applies to.
//
// Optional feature: define ENIGMA_SINK_STALL_EN to build a 16-bit Fibonacci
// LFSR (taps 16,14,13,11, seed 16'hACE1) that adds pseudo-random backpressure
// on ready_c. Without it, ready_c depends only on occupancy.
//
// Parameters:
//   DEPTH     retire FIFO entries (power of two, 2..32)
//   BASE_LAT  minimum service cycles per entry (>= 1)
//
// Ports:
//   clk, rst       clock / asynchronous active-high reset
//   valid_c        beat offered by upstream
//   payload_c      128-bit beat payload
//   id_c           6-bit beat id
//   qos_c          2-bit priority, 3 is highest (shortest service)
//   ready_c        sink can take a beat this cycle
//   conflict_c     1-cycle pulse: previous transferred beat hit a busy id
//   release_c      1-cycle pulse: an id retired
//   releaseid_c    id being retired, valid while release_c is high
//   occupancy      live FIFO entries
//   payload_sig    XOR of all accepted payloads
//   conflict_cnt   saturating count of rejected beats
// ============================================================================
module enigma_sink #(
    parameter int DEPTH    = 8,
    parameter int BASE_LAT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_c,
    input  logic [127:0]                 payload_c,
    input  logic [5:0]                   id_c,
    input  logic [1:0]                   qos_c,
    output logic                         ready_c,
    output logic                         conflict_c,
    output logic                         release_c,
    output logic [5:0]                   releaseid_c,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [127:0]                 payload_sig,
    output logic [15:0]                  conflict_cnt
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    // Largest service load is BASE_LAT + 3.
    localparam int SVC_W = $clog2(BASE_LAT + 4);
    localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(DEPTH);

    logic [63:0]      busy;
    logic [5:0]       fifo_id  [DEPTH];
    logic [1:0]       fifo_qos [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [SVC_W-1:0] svc;

    logic             xfer;
    logic             push;
    logic             reject;
    logic             pop;
    logic             fifo_empty;
    logic [5:0]       head_id;
    logic [PTR_W-1:0] next_rd;
    logic [OCC_W-1:0] occ_next;
    logic [SVC_W-1:0] svc_next;
    logic [63:0]      busy_next;
    logic             ready_next;

    // Service load for an entry: BASE_LAT + (3 - qos); 3 - qos == ~qos in 2 bits.
    function automatic logic [SVC_W-1:0] lat(input logic [1:0] q);
        logic [1:0] inv;
        inv = ~q;
        return SVC_W'(BASE_LAT) + SVC_W'(inv);
    endfunction

`ifdef ENIGMA_SINK_STALL_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= lfsr_next;
    end
`endif

    always_comb begin
        xfer       = valid_c && ready_c;
        fifo_empty = (occupancy == '0);
        // The busy check uses the pre-edge map: no bypass from a same-edge release.
        push       = xfer && !busy[id_c];
        reject     = xfer &&  busy[id_c];
        pop        = !fifo_empty && (svc == SVC_W'(1));
        head_id    = fifo_id[rd_ptr];
        next_rd    = rd_ptr + PTR_W'(1);

        occ_next = occupancy;
        unique case ({push, pop})
            2'b10:   occ_next = occupancy + OCC_W'(1);
            2'b01:   occ_next = occupancy - OCC_W'(1);
            default: occ_next = occupancy;
        endcase

        // The head counter reloads whenever a new entry becomes head: either
        // the successor after a pop, or a push landing in an empty/emptying FIFO.
        svc_next = svc;
        if (pop) begin
            if (occupancy > OCC_W'(1)) svc_next = lat(fifo_qos[next_rd]);
            else if (push)             svc_next = lat(qos_c);
            else                       svc_next = '0;
        end else if (fifo_empty) begin
            if (push) svc_next = lat(qos_c);
        end else begin
            svc_next = svc - SVC_W'(1);
        end

        // Released and pushed ids can never coincide: a push needs a clear bit,
        // a release needs a set one.
        busy_next = busy;
        if (pop)  busy_next[head_id] = 1'b0;
        if (push) busy_next[id_c]    = 1'b1;

`ifdef ENIGMA_SINK_STALL_EN
        ready_next = (occ_next < DEPTH_V) && (lfsr_next[1:0] != 2'b00);
`else
        ready_next = (occ_next < DEPTH_V);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            svc          <= '0;
            occupancy    <= '0;
            ready_c      <= 1'b0;
            conflict_c   <= 1'b0;
            release_c    <= 1'b0;
            releaseid_c  <= '0;
            payload_sig  <= '0;
            conflict_cnt <= '0;
        end else begin
            busy       <= busy_next;
            svc        <= svc_next;
            occupancy  <= occ_next;
            ready_c    <= ready_next;
            conflict_c <= reject;
            release_c  <= pop;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr      <= next_rd;
                releaseid_c <= head_id;
            end
            if (push) payload_sig <= payload_sig ^ payload_c;
            if (reject && (conflict_cnt != 16'hFFFF))
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    // Entry storage needs no reset: occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr]  <= id_c;
            fifo_qos[wr_ptr] <= qos_c;
        end
    end

endmodule

// File: tb/tb_enigma_sink.sv
module tb_enigma_sink;

  localparam int DEPTH    = 8;
  localparam int BASE_LAT = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid_c = 1'b0;
  logic [127:0] payload_c = '0;
  logic [5:0]   id_c = '0;
  logic [1:0]   qos_c = '0;
  logic         ready_c;
  logic         conflict_c;
  logic         release_c;
  logic [5:0]   releaseid_c;
  logic [3:0]   occupancy;
  logic [127:0] payload_sig;
  logic [15:0]  conflict_cnt;

  enigma_sink #(.DEPTH(DEPTH), .BASE_LAT(BASE_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_c      (valid_c),
    .payload_c    (payload_c),
    .id_c         (id_c),
    .qos_c        (qos_c),
    .ready_c      (ready_c),
    .conflict_c   (conflict_c),
    .release_c    (release_c),
    .releaseid_c  (releaseid_c),
    .occupancy    (occupancy),
    .payload_sig  (payload_sig),
    .conflict_cnt (conflict_cnt)
  );

  // clock
  always #5 clk = ~clk;

  // reference model: in-order queue of accepted beats, each head retiring
  // a fixed number of edges after it became head
  bit           m_busy [64];
  logic [5:0]   exp_q [$];
  logic [1:0]   qos_q [$];
  int           m_due;
  int           cyc;
  logic         m_fire;
  logic         m_ready;
  logic         m_conflict;
  logic         m_release;
  logic [5:0]   m_relid;
  logic [127:0] m_sig;
  logic [15:0]  m_cnt;
  logic [15:0]  m_lfsr;

  int n_checks = 0;
  int n_fail   = 0;
  int rel_seen = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand_payload();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) m_busy[i] = 1'b0;
    exp_q.delete();
    qos_q.delete();
    m_due      = 0;
    m_fire     = 1'b0;
    m_ready    = 1'b0;
    m_conflict = 1'b0;
    m_release  = 1'b0;
    m_relid    = '0;
    m_sig      = '0;
    m_cnt      = '0;
    m_lfsr     = 16'hACE1;
  endfunction

  // Called right after a rising edge; uses pre-edge model state and inputs.
  function automatic void model_edge();
    logic pop;
    logic hit;
    logic push;
    int   old_n;
    cyc++;
    old_n      = exp_q.size();
    m_fire     = valid_c && m_ready;
    pop        = (old_n > 0) && (cyc == m_due);
    hit        = m_busy[id_c];
    push       = m_fire && !hit;
    m_conflict = m_fire && hit;
    m_release  = pop;
    if (pop) begin
      m_relid = exp_q[0];
      m_busy[exp_q[0]] = 1'b0;
      void'(exp_q.pop_front());
      void'(qos_q.pop_front());
    end
    if (push) begin
      m_busy[id_c] = 1'b1;
      exp_q.push_back(id_c);
      qos_q.push_back(qos_c);
      m_sig = m_sig ^ payload_c;
    end
    if (m_conflict && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if ((pop || (push && old_n == 0)) && exp_q.size() > 0)
      m_due = cyc + BASE_LAT + 3 - int'(qos_q[0]);
    m_ready = (exp_q.size() < DEPTH);
`ifdef ENIGMA_SINK_STALL_EN
    m_lfsr  = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    m_ready = m_ready && (m_lfsr[1:0] != 2'b00);
`endif
  endfunction

  task automatic check_outputs();
    chk("ready_c", 128'(ready_c), 128'(m_ready));
    chk("conflict_c", 128'(conflict_c), 128'(m_conflict));
    chk("release_c", 128'(release_c), 128'(m_release));
    if (m_release) chk("releaseid_c", 128'(releaseid_c), 128'(m_relid));
    chk("occupancy", 128'(occupancy), 128'(exp_q.size()));
    chk("payload_sig", payload_sig, m_sig);
    chk("conflict_cnt", 128'(conflict_cnt), 128'(m_cnt));
  endtask

  // driver: one clock cycle with the given inputs, model update, then check
  task automatic cycle(input logic v, input logic [5:0] id, input logic [1:0] q,
                       input logic [127:0] p);
    valid_c   = v;
    id_c      = id;
    qos_c     = q;
    payload_c = p;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    if (release_c === 1'b1) rel_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 6'd0, 2'd0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) idle(1);
    idle(1);
    chk("drained_occ", 128'(occupancy), 128'(0));
  endtask

  task automatic do_reset();
    valid_c = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_ready", 128'(ready_c), 128'(0));
    chk("rst_releaseid", 128'(releaseid_c), 128'(0));
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
  endtask

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] p;
    int acc;
    int rel;
    int r1;
    int r2;
    int n;
    int idx;
    int base;
    bit saw_full;

    cyc = 0;
    #2;
    do_reset();

    // ready rises on the first edge after reset release
    idle(1);
    chk("ready_after_rst", 128'(ready_c), 128'(1));

    // single beat id 5, qos 3: release L=4 edges after acceptance
    p = rand_payload();
    cycle(1'b1, 6'd5, 2'd3, p);
    acc = cyc;
    rel = -1;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      if (release_c === 1'b1 && releaseid_c === 6'd5 && rel < 0) rel = cyc;
    end
    chk("lat_id5", 128'(rel - acc), 128'(4));
    chk("sig_single", payload_sig, p);
    chk("occ_single", 128'(occupancy), 128'(0));

    // duplicate id 9 while in flight
    cycle(1'b1, 6'd9, 2'd0, rand_payload());
    cycle(1'b1, 6'd9, 2'd0, rand_payload());
    chk("conflict_9", 128'(conflict_c), 128'(1));
    chk("cnt_9", 128'(conflict_cnt), 128'(1));
    chk("occ_9", 128'(occupancy), 128'(1));
    n = 0;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      if (release_c === 1'b1 && releaseid_c === 6'd9) n++;
    end
    chk("rel9_once", 128'(n), 128'(1));

    // stream 16 distinct ids with valid held high: FIFO fills
    idx = 0;
    saw_full = 1'b0;
    base = rel_seen;
    for (int t = 0; t < 300 && idx < 16; t++) begin
      cycle(1'b1, 6'(20 + idx), 2'd0, rand_payload());
      if (m_fire) idx++;
      if (ready_c === 1'b0) saw_full = 1'b1;
    end
    chk("stream_all", 128'(idx), 128'(16));
    chk("stream_full", 128'(saw_full), 128'(1));
    drain();
    chk("stream_rel", 128'(rel_seen - base), 128'(16));

    // qos 0 then 3: in-order retirement, 7 then 4 cycles
    cycle(1'b1, 6'd1, 2'd0, rand_payload());
    acc = cyc;
    cycle(1'b1, 6'd2, 2'd3, rand_payload());
    r1 = -1;
    r2 = -1;
    for (int i = 0; i < 16; i++) begin
      idle(1);
      if (release_c === 1'b1 && releaseid_c === 6'd1) r1 = cyc;
      if (release_c === 1'b1 && releaseid_c === 6'd2) r2 = cyc;
    end
    chk("lat_id1", 128'(r1 - acc), 128'(7));
    chk("gap_id2", 128'(r2 - r1), 128'(4));

    // arrival of id 5 on the same edge id 5 retires, then replay
    cycle(1'b1, 6'd5, 2'd3, rand_payload());
    idle(3);
    cycle(1'b1, 6'd5, 2'd3, rand_payload());
    chk("same_edge_conflict", 128'(conflict_c), 128'(1));
    chk("same_edge_release", 128'(release_c), 128'(1));
    chk("same_edge_relid", 128'(releaseid_c), 128'(5));
    chk("same_edge_cnt", 128'(conflict_cnt), 128'(2));
    cycle(1'b1, 6'd5, 2'd3, rand_payload());
    chk("replay_ok", 128'(conflict_c), 128'(0));
    chk("replay_occ", 128'(occupancy), 128'(1));
    drain();

    // reset with 3 entries in flight
    cycle(1'b1, 6'd3, 2'd1, rand_payload());
    cycle(1'b1, 6'd4, 2'd1, rand_payload());
    cycle(1'b1, 6'd6, 2'd1, rand_payload());
    chk("pre_rst_occ", 128'(occupancy), 128'(3));
    do_reset();
    chk("rst_occ", 128'(occupancy), 128'(0));
    chk("rst_sig", payload_sig, 128'(0));
    chk("rst_cnt", 128'(conflict_cnt), 128'(0));
    base = rel_seen;
    idle(12);
    chk("no_rel_after_rst", 128'(rel_seen - base), 128'(0));
    p = rand_payload();
    cycle(1'b1, 6'd3, 2'd2, p);
    chk("id3_after_rst", 128'(conflict_c), 128'(0));
    chk("sig_after_rst", payload_sig, p);
    drain();

    // randomized traffic over a small id range to provoke conflicts
    for (int t = 0; t < 800; t++) begin
      cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            6'($urandom_range(0, 11)),
            2'($urandom_range(0, 3)),
            rand_payload());
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
